// File: rtl/slrv_exec_ctrl_if.sv
// Command/status bundle between the execution controller and its host/core.
// The master side issues commands and reports the core PC; the slave side is the controller.
interface slrv_exec_ctrl_if #(
  parameter int unsigned IADDR_W = 9,
  parameter int unsigned STEP_W  = 16,
  parameter int unsigned CNT_W   = 32
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [STEP_W-1:0]  cmd_steps;
  logic               bp_en;
  logic [IADDR_W-1:0] bp_addr;
  logic [IADDR_W-1:0] ins_addr;
  logic               imem_busy;
  logic               pc_control;
  logic               ins_mem_en;
  logic               halted;
  logic               bp_hit;
  logic [CNT_W-1:0]   retired_cnt;

  modport master (
    output cmd_valid, cmd_op, cmd_steps, bp_en, bp_addr, ins_addr, imem_busy,
    input  cmd_ready, pc_control, ins_mem_en, halted, bp_hit, retired_cnt
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_steps, bp_en, bp_addr, ins_addr, imem_busy,
    output cmd_ready, pc_control, ins_mem_en, halted, bp_hit, retired_cnt
  );
endinterface

// File: rtl/slrv_exec_ctrl.sv
// Execution controller for the single-cycle SLRV core: grants exec cycles for HALT/RUN/STEP,
// stops on one PC breakpoint, freezes the core while imem is being loaded, counts retirements.
module slrv_exec_ctrl #(
  parameter int unsigned IADDR_W = 9,
  parameter int unsigned STEP_W  = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  slrv_exec_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {StHalt, StRun, StStep, StLoad} state_e;

  localparam logic [1:0] OpHalt  = 2'd0;
  localparam logic [1:0] OpRun   = 2'd1;
  localparam logic [1:0] OpStep  = 2'd2;
  localparam logic [1:0] OpClrCnt = 2'd3;

  state_e            state_q;
  logic [STEP_W-1:0] step_rem_q;
  logic [CNT_W-1:0]  retired_q;
  logic              bp_hit_q;
  logic              skip_bp_q;

  logic              bp_stop;
  logic              exec;
  logic              cmd_ready;
  logic              accept;
  logic [STEP_W-1:0] steps_load;

  always_comb begin
    bp_stop    = bus.bp_en && (bus.ins_addr == bus.bp_addr) && !skip_bp_q;
    exec       = !bus.imem_busy &&
                 (((state_q == StRun) && !bp_stop) || (state_q == StStep));
    cmd_ready  = (state_q != StLoad) && !bus.imem_busy;
    accept     = bus.cmd_valid && cmd_ready;
    steps_load = (bus.cmd_steps == '0) ? STEP_W'(1) : bus.cmd_steps;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= StHalt;
      step_rem_q <= '0;
      retired_q  <= '0;
      bp_hit_q   <= 1'b0;
      skip_bp_q  <= 1'b0;
    end else begin
      bp_hit_q <= 1'b0;

      if (exec) begin
        skip_bp_q <= 1'b0;
        retired_q <= retired_q + CNT_W'(1);
      end
      if ((state_q == StStep) && exec) begin
        step_rem_q <= step_rem_q - STEP_W'(1);
      end

      // Loader ownership beats everything; accept is already masked by imem_busy.
      if (bus.imem_busy) begin
        state_q    <= StLoad;
        step_rem_q <= '0;
      end else if (state_q == StLoad) begin
        state_q <= StHalt;
      end else if (accept && (bus.cmd_op != OpClrCnt)) begin
        case (bus.cmd_op)
          OpHalt: state_q <= StHalt;
          OpRun: begin
            if (state_q != StRun) begin
              state_q   <= StRun;
              skip_bp_q <= 1'b1;
            end
          end
          OpStep: begin
            state_q    <= StStep;
            step_rem_q <= steps_load;
            skip_bp_q  <= 1'b1;
          end
          default: ;
        endcase
      end else if ((state_q == StRun) && bp_stop) begin
        state_q  <= StHalt;
        bp_hit_q <= 1'b1;
      end else if ((state_q == StStep) && exec && (step_rem_q == STEP_W'(1))) begin
        state_q <= StHalt;
      end

      // Clear wins over a coincident retirement.
      if (accept && (bus.cmd_op == OpClrCnt)) begin
        retired_q <= '0;
      end
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.pc_control  = exec;
  assign bus.ins_mem_en  = exec;
  assign bus.halted      = (state_q == StHalt);
  assign bus.bp_hit      = bp_hit_q;
  assign bus.retired_cnt = retired_q;

endmodule
